axi_traffic_gen: RTL and testbench

//  AXI4 master traffic generator and checker for PCIe/DRAM performance tests. Drives the memory-side
//  AXI4 slave (DDR controller or mock DRAM model): writes NUM_BURSTS incrementing-pattern bursts,

---
 rtl/tg_pkg.sv | 30 +++
 rtl/tg_sat_counter.sv | 26 ++
 rtl/axi_traffic_gen.sv | 230 +++++++++++++++++++++++
 tb/tb_axi_traffic_gen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tg_pkg.sv
// Shared state encodings, AXI constants and the data-pattern helper for the traffic generator.
package tg_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_DATA = 3'd2;
  localparam logic [2:0] ST_WR_RESP = 3'd3;
  localparam logic [2:0] ST_RD_ADDR = 3'd4;
  localparam logic [2:0] ST_RD_DATA = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  typedef enum logic [2:0] {
    TG_IDLE    = ST_IDLE,
    TG_WR_ADDR = ST_WR_ADDR,
    TG_WR_DATA = ST_WR_DATA,
    TG_WR_RESP = ST_WR_RESP,
    TG_RD_ADDR = ST_RD_ADDR,
    TG_RD_DATA = ST_RD_DATA,
    TG_DONE    = ST_DONE
  } tg_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // 32-bit pattern word for global beat index g; wraps naturally.
  function automatic logic [31:0] pattern_word(input logic [31:0] seed, input logic [31:0] g);
    return seed + g;
  endfunction

endpackage

// File: rtl/tg_sat_counter.sv
// Saturating up-counter with synchronous clear, used for the cycle and error counters.
module tg_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + CNT_WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/axi_traffic_gen.sv
// AXI4 master that writes incrementing-pattern bursts, reads them back and checks them,
// counting error beats and the cycles spent in each phase.
module axi_traffic_gen
  import tg_pkg::*;
#(
  parameter int ID_WIDTH   = 7,
  parameter int WORD_WIDTH = 512,
  parameter int TG_ID      = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [63:0]             base_addr,
  input  logic [15:0]             num_bursts,
  input  logic [7:0]              burst_len,
  input  logic [31:0]             seed,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic [CNT_WIDTH-1:0]    wr_cycles,
  output logic [CNT_WIDTH-1:0]    rd_cycles,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [63:0]             awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [WORD_WIDTH-1:0]   wdata,
  output logic [WORD_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [63:0]             araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [WORD_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int LANES = WORD_WIDTH / 32;
  localparam int SIZE  = $clog2(WORD_WIDTH / 8);
  localparam logic [ID_WIDTH-1:0] ID_VAL = ID_WIDTH'(TG_ID);

  logic [2:0]  state_reg;
  logic [63:0] base_reg;
  logic [15:0] num_reg;
  logic [7:0]  len_reg;
  logic [31:0] seed_reg;
  logic [15:0] burst_idx_reg;
  logic [7:0]  beat_reg;
  logic [63:0] addr_reg;
  logic [31:0] g_base_reg;

  logic        start_go;
  logic        beat_last;
  logic        last_burst;
  logic [63:0] burst_stride;
  logic [31:0] exp_word;
  logic [LANES-1:0] lane_bad;
  logic        r_fire;
  logic        b_fire;
  logic        r_err;
  logic        b_err;

  assign start_go     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign beat_last    = (beat_reg == len_reg);
  assign last_burst   = (({1'b0, burst_idx_reg} + 17'd1) == {1'b0, num_reg});
  assign burst_stride = (64'(len_reg) + 64'd1) << SIZE;
  assign exp_word     = pattern_word(seed_reg, g_base_reg + 32'(beat_reg));

  // The same per-beat word feeds the write lanes and the read-back comparison.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign wdata[gi*32 +: 32] = exp_word;
      assign lane_bad[gi]       = (rdata[gi*32 +: 32] != exp_word);
    end
  endgenerate

  assign r_fire = rvalid && rready;
  assign b_fire = bvalid && bready;
  // Any fault on a read beat, including a misplaced rlast, costs exactly one count.
  assign r_err  = r_fire && ((|lane_bad) || (rresp != AXI_RESP_OKAY) || (rid != ID_VAL) ||
                             (rlast != beat_last));
  assign b_err  = b_fire && ((bresp != AXI_RESP_OKAY) || (bid != ID_VAL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      base_reg      <= '0;
      num_reg       <= '0;
      len_reg       <= '0;
      seed_reg      <= '0;
      burst_idx_reg <= '0;
      beat_reg      <= '0;
      addr_reg      <= '0;
      g_base_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            base_reg      <= base_addr & ~64'h3F;
            addr_reg      <= base_addr & ~64'h3F;
            num_reg       <= num_bursts;
            len_reg       <= burst_len;
            seed_reg      <= seed;
            burst_idx_reg <= '0;
            beat_reg      <= '0;
            g_base_reg    <= '0;
            state_reg     <= (num_bursts == 16'd0) ? ST_DONE : ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (awready) state_reg <= ST_WR_DATA;
        end
        ST_WR_DATA: begin
          if (wready) begin
            if (beat_last) begin
              beat_reg  <= '0;
              state_reg <= ST_WR_RESP;
            end else begin
              beat_reg <= beat_reg + 8'd1;
            end
          end
        end
        ST_WR_RESP: begin
          if (bvalid) begin
            if (last_burst) begin
              burst_idx_reg <= '0;
              addr_reg      <= base_reg;
              g_base_reg    <= '0;
              state_reg     <= ST_RD_ADDR;
            end else begin
              burst_idx_reg <= burst_idx_reg + 16'd1;
              addr_reg      <= addr_reg + burst_stride;
              g_base_reg    <= g_base_reg + 32'(len_reg) + 32'd1;
              state_reg     <= ST_WR_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (arready) state_reg <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (rvalid) begin
            // A burst closes on rlast or on the last expected beat, whichever is first.
            if (rlast || beat_last) begin
              beat_reg <= '0;
              if (last_burst) begin
                state_reg <= ST_DONE;
              end else begin
                burst_idx_reg <= burst_idx_reg + 16'd1;
                addr_reg      <= addr_reg + burst_stride;
                g_base_reg    <= g_base_reg + 32'(len_reg) + 32'd1;
                state_reg     <= ST_RD_ADDR;
              end
            end else begin
              beat_reg <= beat_reg + 8'd1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  tg_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .inc   (r_err || b_err),
    .count (err_cnt)
  );

  tg_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .inc   ((state_reg == ST_WR_ADDR) || (state_reg == ST_WR_DATA) || (state_reg == ST_WR_RESP)),
    .count (wr_cycles)
  );

  tg_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_go),
    .inc   ((state_reg == ST_RD_ADDR) || (state_reg == ST_RD_DATA)),
    .count (rd_cycles)
  );

  assign busy    = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
  assign done    = (state_reg == ST_DONE);

  assign awid    = ID_VAL;
  assign awaddr  = addr_reg;
  assign awlen   = len_reg;
  assign awsize  = 3'(SIZE);
  assign awburst = AXI_BURST_INCR;
  assign awvalid = (state_reg == ST_WR_ADDR);

  assign wstrb   = '1;
  assign wvalid  = (state_reg == ST_WR_DATA);
  assign wlast   = (state_reg == ST_WR_DATA) && beat_last;

  assign bready  = (state_reg == ST_WR_RESP);

  assign arid    = ID_VAL;
  assign araddr  = addr_reg;
  assign arlen   = len_reg;
  assign arsize  = 3'(SIZE);
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (state_reg == ST_RD_ADDR);

  assign rready  = (state_reg == ST_RD_DATA);

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Randomized bench: mock 64-word DRAM slave with stall/corruption/short-rlast injection,
// checked against a burst-level model of addresses, memory contents and error counts.
module tb_axi_traffic_gen;

  localparam int WW = 512;
  localparam int IW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [63:0]   base_addr = '0;
  logic [15:0]   num_bursts = '0;
  logic [7:0]    burst_len = '0;
  logic [31:0]   seed = '0;
  logic          busy, done;
  logic [31:0]   err_cnt, wr_cycles, rd_cycles;
  logic [IW-1:0] awid, arid;
  logic [63:0]   awaddr, araddr;
  logic [7:0]    awlen, arlen;
  logic [2:0]    awsize, arsize;
  logic [1:0]    awburst, arburst;
  logic          awvalid, wvalid, wlast, bready, arvalid, rready;
  logic          awready = 1'b1, wready = 1'b1, arready = 1'b1;
  logic [WW-1:0] wdata, rdata;
  logic [WW/8-1:0] wstrb;
  logic          bvalid = 1'b0;
  logic          rvalid, rlast;

  always #5 clk = ~clk;

  axi_traffic_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .burst_len(burst_len), .seed(seed),
    .busy(busy), .done(done), .err_cnt(err_cnt), .wr_cycles(wr_cycles), .rd_cycles(rd_cycles),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid('0), .bresp(2'b00), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid('0), .rdata(rdata), .rresp(2'b00), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  // ---------------- mock DRAM slave ----------------
  logic [WW-1:0] mem [64];
  logic          stall_en = 1'b0;
  logic [31:0]   corrupt_beat = 32'hFFFF_FFFF;
  logic [31:0]   short_beat = 32'hFFFF_FFFF;
  logic [5:0]    w_ptr = '0, r_ptr = '0;
  logic [7:0]    r_left = '0;
  logic          r_act = 1'b0;
  logic          rv_gate = 1'b1;
  logic [31:0]   rd_beat_cnt = '0;

  assign rvalid = r_act && rv_gate;
  assign rlast  = (r_left == 8'd0) || (rd_beat_cnt == short_beat);
  assign rdata  = mem[r_ptr] ^ ((rd_beat_cnt == corrupt_beat) ? WW'(1) : WW'(0));

  always @(posedge clk) begin
    awready <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    wready  <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    arready <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    rv_gate <= stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (!rst_n) begin
      bvalid <= 1'b0;
      r_act  <= 1'b0;
    end else begin
      if (awvalid && awready) w_ptr <= awaddr[11:6];
      if (wvalid && wready) begin
        mem[w_ptr] <= wdata;
        w_ptr      <= w_ptr + 6'd1;
        if (wlast) bvalid <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (arvalid && arready) begin
        r_ptr  <= araddr[11:6];
        r_left <= arlen;
        r_act  <= 1'b1;
      end
      if (rvalid && rready) begin
        r_ptr       <= r_ptr + 6'd1;
        r_left      <= r_left - 8'd1;
        rd_beat_cnt <= rd_beat_cnt + 32'd1;
        if (rlast) r_act <= 1'b0;
      end
    end
  end

  // ---------------- monitor (monotonic tallies only) ----------------
  logic [63:0] aw_q [$];
  logic [63:0] ar_q [$];
  int          busy_cyc = 0, valid_cyc = 0, w_beats = 0, stab_viol = 0;
  logic        aw_wait = 1'b0, w_wait = 1'b0, ar_wait = 1'b0;
  logic [63:0] aw_addr_p = '0, ar_addr_p = '0;
  logic [WW-1:0] w_data_p = '0;
  logic        w_last_p = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      aw_wait <= 1'b0;
      w_wait  <= 1'b0;
      ar_wait <= 1'b0;
    end else begin
      if (busy) busy_cyc <= busy_cyc + 1;
      if (awvalid || wvalid || arvalid) valid_cyc <= valid_cyc + 1;
      if (wvalid && wready) w_beats <= w_beats + 1;
      if (awvalid && awready) aw_q.push_back(awaddr);
      if (arvalid && arready) ar_q.push_back(araddr);
      if ((aw_wait && (!awvalid || awaddr != aw_addr_p)) ||
          (w_wait && (!wvalid || wdata != w_data_p || wlast != w_last_p)) ||
          (ar_wait && (!arvalid || araddr != ar_addr_p)))
        stab_viol <= stab_viol + 1;
      aw_wait   <= awvalid && !awready;
      w_wait    <= wvalid && !wready;
      ar_wait   <= arvalid && !arready;
      aw_addr_p <= awaddr;
      ar_addr_p <= araddr;
      w_data_p  <= wdata;
      w_last_p  <= wlast;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WW-1:0] rep_word(input logic [31:0] w);
    logic [WW-1:0] r;
    for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = w;
    return r;
  endfunction

  int snap_aw, snap_ar, snap_busy, snap_valid, snap_stab, snap_w;
  logic [31:0] snap_rd;

  task automatic take_snap();
    snap_aw    = aw_q.size();
    snap_ar    = ar_q.size();
    snap_busy  = busy_cyc;
    snap_valid = valid_cyc;
    snap_stab  = stab_viol;
    snap_w     = w_beats;
    snap_rd    = rd_beat_cnt;
  endtask

  task automatic pulse_start(input logic [63:0] b, input logic [15:0] n,
                             input logic [7:0] l, input logic [31:0] s);
    base_addr  = b;
    num_bursts = n;
    burst_len  = l;
    seed       = s;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 6000; i++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check("done_within_budget", done, 1'b1);
  endtask

  // Burst-level model: every recorded address, every written word, error and cycle totals.
  task automatic check_run(input string tag, input logic [63:0] b, input int n, input int l,
                           input logic [31:0] s, input int exp_err);
    logic [63:0] a;
    int          idx;
    check({tag, "_busy_low"}, busy, 1'b0);
    check({tag, "_err_cnt"}, err_cnt, exp_err);
    check({tag, "_aw_count"}, aw_q.size() - snap_aw, n);
    check({tag, "_ar_count"}, ar_q.size() - snap_ar, n);
    for (int k = 0; k < n; k++) begin
      a = (b & ~64'h3F) + 64'(k) * 64'(l + 1) * 64'd64;
      if (snap_aw + k < aw_q.size()) check({tag, "_awaddr"}, aw_q[snap_aw + k], a);
      if (snap_ar + k < ar_q.size()) check({tag, "_araddr"}, ar_q[snap_ar + k], a);
    end
    for (int g = 0; g < n * (l + 1); g++) begin
      idx = (int'(b[11:6]) + g) % 64;
      check({tag, "_mem"}, mem[idx], rep_word(s + 32'(g)));
    end
    check({tag, "_cycles_sum"}, wr_cycles + rd_cycles, busy_cyc - snap_busy);
    check({tag, "_stable_while_stalled"}, stab_viol - snap_stab, 0);
  endtask

  initial begin : main
    logic [63:0] b;
    logic [31:0] s;
    int n, l, total, ci, exp_err;
    logic do_short, do_corrupt;

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {busy, done, awvalid, wvalid, arvalid, bready, rready},
          7'b0);
    check("reset_counters", {err_cnt, wr_cycles, rd_cycles}, 96'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Test 1: basic run
    take_snap();
    pulse_start(64'h0, 16'd2, 8'd3, 32'h100);
    check("t1_busy_after_start", busy, 1'b1);
    wait_done();
    check_run("t1", 64'h0, 2, 3, 32'h100, 0);
    check("t1_aw1", aw_q[snap_aw + 1], 64'h100);
    check("t1_mem7", mem[7], rep_word(32'h107));

    // Test 4: zero-burst start clears the previous counters and goes straight to DONE
    take_snap();
    pulse_start(64'h1000, 16'd0, 8'd3, 32'h5);
    check("t4_done_next_cycle", done, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("t4_no_valids", valid_cyc - snap_valid, 0);
    check("t4_counters_zero", {err_cnt, wr_cycles, rd_cycles}, 96'd0);
    check("t4_busy_low", busy, 1'b0);

    // Test 2: stalls
    stall_en = 1'b1;
    take_snap();
    pulse_start(64'h0, 16'd2, 8'd3, 32'h100);
    wait_done();
    check_run("t2", 64'h0, 2, 3, 32'h100, 0);
    stall_en = 1'b0;

    // Test 3: corrupted read beat 5
    take_snap();
    corrupt_beat = snap_rd + 32'd5;
    pulse_start(64'h0, 16'd2, 8'd3, 32'h2000);
    wait_done();
    check_run("t3", 64'h0, 2, 3, 32'h2000, 1);
    corrupt_beat = 32'hFFFF_FFFF;

    // Test 6: start while busy is ignored, then a back-to-back wrapping-seed run
    take_snap();
    pulse_start(64'h40, 16'd2, 8'd3, 32'h77);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(64'h800, 16'd0, 8'd1, 32'hDEAD);
    wait_done();
    check_run("t6_ignored", 64'h40, 2, 3, 32'h77, 0);
    take_snap();
    pulse_start(64'h0, 16'd2, 8'd3, 32'hFFFF_FFFF);
    wait_done();
    check_run("t6_wrap", 64'h0, 2, 3, 32'hFFFF_FFFF, 0);
    check("t6_wrap_word1", mem[1], rep_word(32'h0));

    // Randomized runs with optional stalls, corruption and a short first read burst
    for (int t = 0; t < 8; t++) begin
      n  = $urandom_range(1, 4);
      l  = $urandom_range(0, (64 / n - 1 > 15) ? 15 : 64 / n - 1);
      b  = {$urandom, $urandom};
      s  = $urandom;
      stall_en   = ($urandom_range(0, 1) == 1);
      do_short   = (l > 0) && ($urandom_range(0, 2) == 0);
      do_corrupt = ($urandom_range(0, 1) == 1);
      total      = n * (l + 1) - (do_short ? l : 0);
      ci         = $urandom_range(0, total - 1);
      take_snap();
      short_beat   = do_short ? snap_rd : 32'hFFFF_FFFF;
      corrupt_beat = do_corrupt ? snap_rd + 32'(ci) : 32'hFFFF_FFFF;
      exp_err = (do_short ? 1 : 0) + (do_corrupt ? 1 : 0) - ((do_short && do_corrupt && ci == 0) ? 1 : 0);
      pulse_start(b, 16'(n), 8'(l), s);
      wait_done();
      check_run("rand", b, n, l, s, exp_err);
      short_beat   = 32'hFFFF_FFFF;
      corrupt_beat = 32'hFFFF_FFFF;
    end
    stall_en = 1'b0;

    // Test 5: reset during write beat 2
    take_snap();
    pulse_start(64'h0, 16'd2, 8'd3, 32'h300);
    for (int i = 0; i < 200; i++) begin
      if (w_beats - snap_w >= 2) break;
      @(posedge clk); #1;
    end
    check("t5_reached_beat2", w_beats - snap_w, 2);
    check("t5_in_write_data", wvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_valids_low", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
    check("t5_busy_done_low", {busy, done}, 2'b0);
    check("t5_counters_zero", {err_cnt, wr_cycles, rd_cycles}, 96'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_idle_after_release", {busy, done, awvalid}, 3'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
